// File: rtl/mp_operand_loader.sv
// Assembles two wide operands from a narrow LSW-first word stream and launches
// the multi-precision adder, holding the operands until the adder reports done.
module mp_operand_loader #(
  parameter int unsigned OPERAND_WIDTH = 128,
  parameter int unsigned WORD_WIDTH    = 32
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic [WORD_WIDTH-1:0]    iWord,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  output logic                     oStart,
  input  logic                     iDone,
  output logic                     oBusy
);

  localparam int unsigned NUM_WORDS = OPERAND_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_START  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] op_a_q, op_a_d;
  logic [OPERAND_WIDTH-1:0] op_b_q, op_b_d;
  logic                     start_q, start_d;
  logic                     busy_q, busy_d;
  logic                     load_c;
  logic                     xfer_c;
  logic                     last_c;

  // Ready is a pure state decode, forced low while reset is held.
  assign load_c = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign oReady = load_c && iRstN;
  assign xfer_c = iValid && load_c;
  assign last_c = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;

    case (state_q)
      ST_LOAD_A: begin
        if (xfer_c) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) op_a_d[k*WORD_WIDTH +: WORD_WIDTH] = iWord;
          end
          if (last_c) begin
            cnt_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (xfer_c) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) op_b_d[k*WORD_WIDTH +: WORD_WIDTH] = iWord;
          end
          if (last_c) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Done is level-sampled; leaving WAIT on the first sample prevents relaunch.
        if (iDone) state_d = ST_LOAD_A;
      end
      default: state_d = ST_LOAD_A;
    endcase

    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_START) || (state_d == ST_WAIT);
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign oOpA   = op_a_q;
  assign oOpB   = op_b_q;
  assign oStart = start_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_mp_operand_loader.sv
// Directed bench for mp_operand_loader; a scoreboard of expected operand pairs
// is checked on every launch pulse.
module tb_mp_operand_loader;

  localparam int unsigned OW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned NW = OW / WW;

  localparam logic [OW-1:0] A1 = 128'hffffffff_ffffffff_fffff0ff_0fffff00;
  localparam logic [OW-1:0] B1 = 128'hffffffff_fffff0ff_ffffffff_0fffffff;
  localparam logic [OW-1:0] A2 = 128'h0;
  localparam logic [OW-1:0] B2 = 128'h1;
  localparam logic [OW-1:0] A3 = 128'h01234567_89abcdef_02468ace_13579bdf;
  localparam logic [OW-1:0] B3 = 128'hfedcba98_76543210_aaaa5555_0f0f0f0f;

  typedef struct packed {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
  } pair_t;

  logic          iClk   = 1'b0;
  logic          iRstN  = 1'b0;
  logic [WW-1:0] iWord  = '0;
  logic          iValid = 1'b0;
  logic          iDone  = 1'b0;
  logic          oReady;
  logic [OW-1:0] oOpA;
  logic [OW-1:0] oOpB;
  logic          oStart;
  logic          oBusy;

  pair_t sb[$];
  int    n_cmp   = 0;
  int    n_mis   = 0;
  int    n_start = 0;
  int    n_xfer  = 0;

  always #5 iClk = ~iClk;

  mp_operand_loader #(.OPERAND_WIDTH(OW), .WORD_WIDTH(WW)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iWord  (iWord),
    .iValid (iValid),
    .oReady (oReady),
    .oOpA   (oOpA),
    .oOpB   (oOpB),
    .oStart (oStart),
    .iDone  (iDone),
    .oBusy  (oBusy)
  );

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge iClk) begin
    if (iRstN && iValid && oReady) n_xfer++;
  end

  // Every launch pops the oldest expected pair.
  always @(negedge iClk) begin : mon
    pair_t e;
    if (oStart === 1'b1) begin
      n_start++;
      chk("sb_nonempty_at_start", OW'(sb.size() > 0), OW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("start_opA", oOpA, e.a);
        chk("start_opB", oOpB, e.b);
      end
    end
  end

  task automatic send(input logic [WW-1:0] w);
    int t = 0;
    iWord  = w;
    iValid = 1'b1;
    while (oReady !== 1'b1 && t < 100) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", OW'(t), OW'(0));
    @(negedge iClk);
  endtask

  task automatic send_pair(input logic [OW-1:0] a, input logic [OW-1:0] b, input int gap);
    for (int k = 0; k < NW; k++) begin
      send(a[k*WW +: WW]);
      if (gap > 0) begin
        iValid = 1'b0;
        repeat (gap) @(negedge iClk);
      end
    end
    for (int k = 0; k < NW; k++) begin
      if (k == NW - 1) sb.push_back({a, b});
      send(b[k*WW +: WW]);
      if (gap > 0 && k != NW - 1) begin
        iValid = 1'b0;
        repeat (gap) @(negedge iClk);
      end
    end
    iValid = 1'b0;
    chk("start_latency", OW'(oStart), OW'(1));
    chk("busy_at_start", OW'(oBusy), OW'(1));
  endtask

  task automatic wait_check(input logic [OW-1:0] a, input logic [OW-1:0] b);
    iValid = 1'b1;
    iWord  = 32'hdeadbeef;
    repeat (5) @(negedge iClk);
    chk("wait_ready", OW'(oReady), OW'(0));
    chk("wait_busy", OW'(oBusy), OW'(1));
    chk("wait_start", OW'(oStart), OW'(0));
    chk("wait_opA", oOpA, a);
    chk("wait_opB", oOpB, b);
    iValid = 1'b0;
  endtask

  task automatic finish_add();
    iDone = 1'b1;
    @(negedge iClk);
    iDone = 1'b0;
    chk("ready_after_done", OW'(oReady), OW'(1));
    chk("busy_after_done", OW'(oBusy), OW'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int x0;
    int s0;
    int acc;
    logic r;

    // Reset held with valid asserted.
    iValid = 1'b1;
    iWord  = 32'hcafef00d;
    repeat (5) @(negedge iClk);
    chk("rst_ready", OW'(oReady), OW'(0));
    chk("rst_start", OW'(oStart), OW'(0));
    chk("rst_busy", OW'(oBusy), OW'(0));
    chk("rst_opA", oOpA, OW'(0));
    chk("rst_opB", oOpB, OW'(0));
    iRstN  = 1'b1;
    iValid = 1'b0;
    #1;
    chk("ready_after_rst", OW'(oReady), OW'(1));
    @(negedge iClk);

    // Back-to-back pair.
    send_pair(A1, B1, 0);
    @(negedge iClk);
    chk("start_one_cycle", OW'(oStart), OW'(0));
    wait_check(A1, B1);
    finish_add();

    // Gapped valid: one word every three cycles.
    x0 = n_xfer;
    s0 = n_start;
    send_pair(A3, B3, 2);
    chk("gapped_xfers", OW'(n_xfer - x0), OW'(8));
    wait_check(A3, B3);
    chk("gapped_starts", OW'(n_start - s0), OW'(1));
    finish_add();

    // Long done with valid held; next pair (A=0, B=1) streams in behind it.
    send_pair(A1, B1, 0);
    wait_check(A1, B1);
    s0     = n_start;
    iDone  = 1'b1;
    iValid = 1'b1;
    iWord  = '0;
    acc    = 0;
    for (int i = 0; i < 4; i++) begin
      r = oReady;
      chk((i == 0) ? "hold_ready_wait" : "hold_ready_load", OW'(r), OW'(i != 0));
      chk("hold_start", OW'(oStart), OW'(0));
      if (i == 0) chk("hold_opA_wait", oOpA, A1);
      acc += int'(r);
      @(negedge iClk);
    end
    iDone  = 1'b0;
    iValid = 1'b0;
    chk("no_relaunch", OW'(n_start - s0), OW'(0));
    for (int k = acc; k < NW; k++) send(A2[k*WW +: WW]);
    for (int k = 0; k < NW; k++) begin
      if (k == NW - 1) sb.push_back({A2, B2});
      send(B2[k*WW +: WW]);
    end
    iValid = 1'b0;
    chk("pair2_start", OW'(oStart), OW'(1));
    @(negedge iClk);
    chk("pair2_start_count", OW'(n_start - s0), OW'(1));
    finish_add();

    // Reset mid-B discards the partial pair.
    for (int k = 0; k < NW; k++) send(A3[k*WW +: WW]);
    send(B3[WW-1:0]);
    iRstN  = 1'b0;
    iValid = 1'b1;
    repeat (2) @(negedge iClk);
    chk("abort_opA", oOpA, OW'(0));
    chk("abort_opB", oOpB, OW'(0));
    chk("abort_busy", OW'(oBusy), OW'(0));
    chk("abort_ready", OW'(oReady), OW'(0));
    iRstN  = 1'b1;
    iValid = 1'b0;
    s0     = n_start;
    repeat (4) @(negedge iClk);
    chk("abort_no_start", OW'(n_start - s0), OW'(0));
    send_pair(A3, B3, 0);
    wait_check(A3, B3);
    finish_add();

    repeat (2) @(negedge iClk);
    chk("sb_drained", OW'(sb.size()), OW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
